dispatch_queue: RTL and testbench

//   In-order dispatch buffer between the decoders and the reservation stations.

---
 rtl/dispatch_queue.sv | 154 +++++++++++++++
 tb/tb_dispatch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order dispatch buffer between the decoders and the
// reservation stations. Decoded instructions enter a circular FIFO one per
// cycle; the head entry is steered to the station named by its funcUnitType
// and held while that station reports full.
//
// Ports:
//   clock_i, reset_i     clock (posedge) and async active-high reset
//   enable_i             decoder presents a valid instruction
//   flush_i              synchronous discard of all queued entries
//   funcUnitType_i       target station index of the incoming instruction
//   majID_i, payload_i   instruction ID and remaining decoded fields
//   rsIsFull_i           per-station full flags
//   enable_o             registered one-hot dispatch strobe
//   funcUnitType_o, majID_o, payload_o   fields of the last dispatched entry
//   stall_o              queue full, decoder must hold
//   count_o              current occupancy
//   error_o              sticky: illegal funcUnitType seen
module dispatch_queue #(
  parameter int unsigned NumRS                   = 4,
  parameter int unsigned QueueIdxBits            = 2,
  parameter int unsigned funcUnitCodeSize        = 3,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned PayloadWidth            = 224
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic                               flush_i,
  input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
  input  logic [instructionCounterWidth-1:0] majID_i,
  input  logic [PayloadWidth-1:0]            payload_i,
  input  logic [NumRS-1:0]                   rsIsFull_i,
  output logic [NumRS-1:0]                   enable_o,
  output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
  output logic [instructionCounterWidth-1:0] majID_o,
  output logic [PayloadWidth-1:0]            payload_o,
  output logic                               stall_o,
  output logic [QueueIdxBits:0]              count_o,
  output logic                               error_o
);

  localparam int unsigned Depth = 1 << QueueIdxBits;
  localparam int unsigned CntW  = QueueIdxBits + 1;

  typedef struct packed {
    logic [funcUnitCodeSize-1:0]        fu_type;
    logic [instructionCounterWidth-1:0] maj_id;
    logic [PayloadWidth-1:0]            payload;
  } entry_t;

  entry_t                            mem_q [Depth];
  logic [QueueIdxBits-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]                   count_q, count_d;
  logic                              stall_q, stall_d;
  logic                              error_q, error_d;
  logic [NumRS-1:0]                  enable_q, enable_d;
  logic [funcUnitCodeSize-1:0]       type_q, type_d;
  logic [instructionCounterWidth-1:0] maj_q, maj_d;
  logic [PayloadWidth-1:0]           pay_q, pay_d;

  entry_t head_entry_c;
  logic   head_blocked_c;
  logic   type_legal_c;
  logic   enq_c;
  logic   deq_c;

  assign head_entry_c = mem_q[head_q];

  // Next-state: enqueue/dispatch decisions, pointer and counter updates.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    enable_d = '0;
    type_d   = type_q;
    maj_d    = maj_q;
    pay_d    = pay_q;

    // Out-of-range head types cannot occur; treat them as blocked anyway.
    head_blocked_c = 1'b1;
    for (int unsigned k = 0; k < NumRS; k++) begin
      if (head_entry_c.fu_type == funcUnitCodeSize'(k)) head_blocked_c = rsIsFull_i[k];
    end

    type_legal_c = 32'(funcUnitType_i) < NumRS;
    // Full check uses the current count: a slot freed this edge is not reusable yet.
    enq_c = enable_i && !flush_i && type_legal_c && (count_q < CntW'(Depth));
    deq_c = !flush_i && (count_q != '0) && !head_blocked_c;

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_c) tail_d = tail_q + 1'b1;
      if (deq_c) begin
        head_d = head_q + 1'b1;
        type_d = head_entry_c.fu_type;
        maj_d  = head_entry_c.maj_id;
        pay_d  = head_entry_c.payload;
        for (int unsigned k = 0; k < NumRS; k++) begin
          enable_d[k] = (head_entry_c.fu_type == funcUnitCodeSize'(k));
        end
      end
      case ({enq_c, deq_c})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    stall_d = (count_d == CntW'(Depth));
    error_d = error_q | (enable_i && !type_legal_c);
  end

  // Control and output registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
      error_q  <= 1'b0;
      enable_q <= '0;
      type_q   <= '0;
      maj_q    <= '0;
      pay_q    <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      error_q  <= error_d;
      enable_q <= enable_d;
      type_q   <= type_d;
      maj_q    <= maj_d;
      pay_q    <= pay_d;
    end
  end

  // Entry storage; contents are only read while count is non-zero.
  always_ff @(posedge clock_i) begin
    if (enq_c) mem_q[tail_q] <= '{fu_type: funcUnitType_i, maj_id: majID_i, payload: payload_i};
  end

  assign enable_o       = enable_q;
  assign funcUnitType_o = type_q;
  assign majID_o        = maj_q;
  assign payload_o      = pay_q;
  assign stall_o        = stall_q;
  assign count_o        = count_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Testbench for dispatch_queue: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_dispatch_queue;

  localparam int unsigned NumRS = 4;
  localparam int unsigned FW    = 3;
  localparam int unsigned IW    = 64;
  localparam int unsigned PW    = 224;
  localparam int unsigned Depth = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en, flush;
  logic [FW-1:0]   ftype;
  logic [IW-1:0]   maj;
  logic [PW-1:0]   pay;
  logic [NumRS-1:0] rsfull;
  logic [NumRS-1:0] en_o;
  logic [FW-1:0]   type_o;
  logic [IW-1:0]   maj_o;
  logic [PW-1:0]   pay_o;
  logic            stall_o, err_o;
  logic [2:0]      count_o;

  int checks = 0;
  int failures = 0;

  dispatch_queue dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .flush_i(flush),
    .funcUnitType_i(ftype), .majID_i(maj), .payload_i(pay), .rsIsFull_i(rsfull),
    .enable_o(en_o), .funcUnitType_o(type_o), .majID_o(maj_o), .payload_o(pay_o),
    .stall_o(stall_o), .count_o(count_o), .error_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   t;
    logic [IW-1:0] m;
    logic [PW-1:0] p;
  } ent_t;

  ent_t             mq[$];
  logic [NumRS-1:0] m_en;
  logic [FW-1:0]    m_type;
  logic [IW-1:0]    m_maj;
  logic [PW-1:0]    m_pay;
  logic             m_err;

  function automatic logic [PW-1:0] pat(input logic [IW-1:0] id);
    return {7{32'hC0DE_0000 + id[31:0]}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO semantics straight from the rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_en = '0; m_type = '0; m_maj = '0; m_pay = '0; m_err = 1'b0;
    end else begin
      int unsigned pre;
      ent_t e;
      pre = mq.size();
      if (en && 32'(ftype) >= NumRS) m_err = 1'b1;
      m_en = '0;
      if (flush) begin
        mq.delete();
      end else begin
        if (pre > 0 && !rsfull[mq[0].t]) begin
          e = mq.pop_front();
          m_en = NumRS'(1) << e.t;
          m_type = FW'(e.t); m_maj = e.m; m_pay = e.p;
        end
        if (en && 32'(ftype) < NumRS && pre < Depth) begin
          e.t = 32'(ftype); e.m = maj; e.p = pay;
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("enable_o", 256'(en_o), 256'(m_en));
    chk("funcUnitType_o", 256'(type_o), 256'(m_type));
    chk("majID_o", 256'(maj_o), 256'(m_maj));
    chk("payload_o", 256'(pay_o), 256'(m_pay));
    chk("count_o", 256'(count_o), 256'(mq.size()));
    chk("stall_o", 256'(stall_o), 256'(mq.size() == Depth));
    chk("error_o", 256'(err_o), 256'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int unsigned t, input int unsigned id);
    en = 1'b1; ftype = FW'(t); maj = IW'(id); pay = pat(IW'(id));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; ftype = '0; maj = '0; pay = '0; rsfull = '0;
    #3;
    chk("reset enable_o", 256'(en_o), 256'(0));
    chk("reset count_o", 256'(count_o), 256'(0));
    chk("reset stall_o", 256'(stall_o), 256'(0));
    chk("reset error_o", 256'(err_o), 256'(0));
    #9 rst = 1'b0;

    // 1: single entry, one-cycle latency
    push(2, 5);
    tick();
    chk("t1 count after enq", 256'(count_o), 256'(1));
    chk("t1 no bypass", 256'(en_o), 256'(0));
    en = 1'b0;
    tick();
    chk("t1 enable_o", 256'(en_o), 256'(4'b0100));
    chk("t1 majID_o", 256'(maj_o), 256'(5));
    chk("t1 count drained", 256'(count_o), 256'(0));
    tick();
    chk("t1 pulse ends", 256'(en_o), 256'(0));

    // 2: fill while all stations full, 5th enqueue ignored, drain in order
    rsfull = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      push(i % 4, 10 + i);
      tick();
    end
    chk("t2 count full", 256'(count_o), 256'(4));
    chk("t2 stall", 256'(stall_o), 256'(1));
    push(0, 14);
    tick();
    chk("t2 5th ignored", 256'(count_o), 256'(4));
    en = 1'b0; rsfull = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2 drain majID", 256'(maj_o), 256'(10 + i));
      chk("t2 drain enable", 256'(en_o), 256'(1 << (i % 4)));
    end
    chk("t2 empty", 256'(count_o), 256'(0));

    // 3: blocked head blocks a younger entry for a free station
    rsfull = 4'b0010;
    push(1, 20); tick();
    push(0, 21); tick();
    en = 1'b0;
    tick();
    chk("t3 blocked", 256'(en_o), 256'(0));
    chk("t3 count held", 256'(count_o), 256'(2));
    rsfull = '0;
    tick();
    chk("t3 first type1", 256'(en_o), 256'(4'b0010));
    chk("t3 first majID", 256'(maj_o), 256'(20));
    tick();
    chk("t3 then type0", 256'(en_o), 256'(4'b0001));
    chk("t3 then majID", 256'(maj_o), 256'(21));

    // 4: steady stream, pointers wrap
    push(0, 0); tick();
    for (int i = 1; i < 10; i++) begin
      push(i % 4, i);
      tick();
      chk("t4 count steady", 256'(count_o), 256'(1));
      chk("t4 majID order", 256'(maj_o), 256'(i - 1));
    end
    en = 1'b0;
    tick();
    chk("t4 last majID", 256'(maj_o), 256'(9));
    chk("t4 drained", 256'(count_o), 256'(0));

    // 5: illegal type
    rsfull = 4'b1111;
    push(3, 30); tick();
    push(5, 31); tick();
    chk("t5 error set", 256'(err_o), 256'(1));
    chk("t5 count unchanged", 256'(count_o), 256'(1));
    en = 1'b0;
    tick(); tick();
    chk("t5 error sticky", 256'(err_o), 256'(1));

    // 6: flush with three held entries, then async reset mid-dispatch
    push(0, 32); tick();
    push(1, 33); tick();
    en = 1'b0;
    chk("t6 count before flush", 256'(count_o), 256'(3));
    flush = 1'b1; rsfull = '0;
    tick();
    chk("t6 flush count", 256'(count_o), 256'(0));
    chk("t6 flush no enable", 256'(en_o), 256'(0));
    flush = 1'b0;
    tick();
    chk("t6 stays empty", 256'(en_o), 256'(0));
    push(2, 40); tick();
    push(3, 41); tick();
    en = 1'b0;
    chk("t6 dispatching", 256'(en_o), 256'(4'b0100));
    #1 rst = 1'b1;
    #1;
    chk("t6 async enable", 256'(en_o), 256'(0));
    chk("t6 async majID", 256'(maj_o), 256'(0));
    chk("t6 async payload", 256'(pay_o), 256'(0));
    chk("t6 async count", 256'(count_o), 256'(0));
    chk("t6 async error", 256'(err_o), 256'(0));
    #3 rst = 1'b0;
    tick();
    chk("t6 post reset count", 256'(count_o), 256'(0));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
